// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode/func and ALU-control encodings shared by the multi-cycle control unit.
package mc_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7
    } alu_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                          OP_ORI, OP_XORI, OP_LW, OP_SW};
    endfunction
endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// mc_alu_dec: combinational ALU-control decode; non-ADD codes only appear in EX.
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic [5:0] i_func,
    output alu_t       o_alu_ctl
);
    always_comb begin
        o_alu_ctl = ALU_ADD;
        if (i_state == S_EX) begin
            case (i_op)
                OP_RTYPE: case (i_func)
                    FN_SUB:  o_alu_ctl = ALU_SUB;
                    FN_AND:  o_alu_ctl = ALU_AND;
                    FN_OR:   o_alu_ctl = ALU_OR;
                    FN_XOR:  o_alu_ctl = ALU_XOR;
                    FN_NOR:  o_alu_ctl = ALU_NOR;
                    FN_SLT:  o_alu_ctl = ALU_SLT;
                    FN_SLL:  o_alu_ctl = ALU_SLL;
                    default: o_alu_ctl = ALU_ADD;
                endcase
                OP_BEQ, OP_BNE: o_alu_ctl = ALU_SUB;
                OP_ANDI:        o_alu_ctl = ALU_AND;
                OP_ORI:         o_alu_ctl = ALU_OR;
                OP_XORI:        o_alu_ctl = ALU_XOR;
                default:        o_alu_ctl = ALU_ADD;
            endcase
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with retired-instruction counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP and raise illegal.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [5:0]       op,
    input  logic [5:0]       func,
    input  logic             zero,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             alu_src_b,
    output logic             ext_sign,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic [3:0]       alu_ctl,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] inst_cnt
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);
    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    alu_t             w_alu_ctl;
    logic             w_ir, w_pcw, w_rw, w_rd, w_asb, w_ext, w_m2r, w_mw, w_ret, w_ill;
    logic [1:0]       w_pcsrc;
    logic             w_live, w_en;

    mc_alu_dec u_alu_dec (
        .i_state   (r_state),
        .i_op      (op),
        .i_func    (func),
        .o_alu_ctl (w_alu_ctl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IF;
            r_cnt   <= '0;
        end else if (!hold) begin
            r_state <= w_next;
            if (w_ret) r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ir    = 1'b0;
        w_pcw   = 1'b0;
        w_pcsrc = 2'd0;
        w_rw    = 1'b0;
        w_rd    = 1'b0;
        w_asb   = 1'b0;
        w_ext   = 1'b0;
        w_m2r   = 1'b0;
        w_mw    = 1'b0;
        w_ret   = 1'b0;
        w_ill   = 1'b0;
        case (r_state)
            S_IF: begin
                w_ir   = 1'b1;
                w_pcw  = 1'b1;
                w_next = S_ID;
            end
            S_ID: begin
                if (op == OP_J) begin
                    w_pcw   = 1'b1;
                    w_pcsrc = 2'd2;
                    w_ret   = 1'b1;
                    w_next  = S_IF;
                end else if (op_supported(op)) begin
                    w_next = S_EX;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    w_next = S_TRAP;
`else
                    w_ret  = 1'b1;
                    w_next = S_IF;
`endif
                end
            end
            S_EX: begin
                w_ext  = op inside {OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE};
                w_asb  = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW};
                w_next = (op inside {OP_LW, OP_SW}) ? S_MEM : (op inside {OP_BEQ, OP_BNE}) ? S_IF : S_WB;
                if (op inside {OP_BEQ, OP_BNE}) begin
                    w_pcsrc = 2'd1;
                    w_pcw   = (op == OP_BEQ) ? zero : !zero;
                    w_ret   = 1'b1;
                end
            end
            S_MEM: begin
                w_mw   = op == OP_SW;
                w_ret  = op == OP_SW;
                w_next = (op == OP_SW) ? S_IF : S_WB;
            end
            S_WB: begin
                w_rw   = 1'b1;
                w_rd   = op == OP_RTYPE;
                w_m2r  = op == OP_LW;
                w_ret  = 1'b1;
                w_next = S_IF;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: w_ill = 1'b1;
`endif
            default: w_next = S_IF;
        endcase
    end

    // Reset blanks every output; hold additionally blanks the write enables and retire.
    assign w_live     = !rst;
    assign w_en       = !rst && !hold;
    assign ir_write   = w_en & w_ir;
    assign pc_write   = w_en & w_pcw;
    assign reg_write  = w_en & w_rw;
    assign mem_write  = w_en & w_mw;
    assign retire     = w_en & w_ret;
    assign pc_src     = w_live ? w_pcsrc : 2'd0;
    assign reg_dst    = w_live & w_rd;
    assign alu_src_b  = w_live & w_asb;
    assign ext_sign   = w_live & w_ext;
    assign mem_to_reg = w_live & w_m2r;
    assign alu_ctl    = w_live ? w_alu_ctl : 4'd0;
    assign state      = w_live ? r_state : 3'd0;
    assign inst_cnt   = w_live ? r_cnt : '0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign illegal    = w_live & w_ill;
`else
    logic w_unused;
    assign w_unused   = w_ill;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed literal checks plus randomized run against a step-indexed instruction model.
module tb_mc_ctrl_fsm;
    localparam int CW = 4;
    localparam int K_J = 0, K_NOP = 1, K_BR = 2, K_ALU = 3, K_SW = 4, K_LW = 5;

    logic          clk = 0, rst = 1, hold = 0, zero = 0;
    logic [5:0]    op = 6'h00, func = 6'h20;
    logic          ir_write, pc_write, reg_write, reg_dst, alu_src_b, ext_sign;
    logic          mem_to_reg, mem_write, retire;
    logic [1:0]    pc_src;
    logic [3:0]    alu_ctl;
    logic [2:0]    state;
    logic [CW-1:0] inst_cnt;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic          illegal;
`endif

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .hold(hold), .op(op), .func(func), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_b(alu_src_b),
        .ext_sign(ext_sign), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .alu_ctl(alu_ctl), .state(state), .retire(retire), .inst_cnt(inst_cnt)
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int m_k = 0, m_cnt = 0;
    bit m_trap = 0, m_on = 0;
    // Per instruction class: state visited at each cycle, and total cycle count.
    int seq [6][5] = '{'{0,1,0,0,0}, '{0,1,0,0,0}, '{0,1,2,0,0}, '{0,1,2,4,0}, '{0,1,2,3,0}, '{0,1,2,3,4}};
    int len [6]    = '{2, 2, 3, 4, 4, 5};
    logic [5:0] ops [13] = '{6'h00,6'h02,6'h04,6'h05,6'h08,6'h0C,6'h0D,6'h0E,6'h23,6'h2B,6'h3F,6'h01,6'h10};
    logic [5:0] fns [10] = '{6'h20,6'h22,6'h24,6'h25,6'h26,6'h27,6'h2A,6'h00,6'h3F,6'h01};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic int cls(input logic [5:0] o);
        case (o)
            6'h02: return K_J;
            6'h04, 6'h05: return K_BR;
            6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E: return K_ALU;
            6'h2B: return K_SW;
            6'h23: return K_LW;
            default: return K_NOP;
        endcase
    endfunction

    function automatic int ealu(input logic [5:0] o, input logic [5:0] f);
        if (o == 6'h00) case (f)
            6'h22: return 1; 6'h24: return 2; 6'h25: return 3; 6'h26: return 4;
            6'h27: return 5; 6'h2A: return 6; 6'h00: return 7; default: return 0;
        endcase
        case (o)
            6'h04, 6'h05: return 1;
            6'h0C: return 2;
            6'h0D: return 3;
            6'h0E: return 4;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_k <= 0; m_cnt <= 0; m_trap <= 0;
        end else if (!m_trap && !hold) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (m_k == 1 && cls(op) == K_NOP) m_trap <= 1;
            else
`endif
            if (m_k == len[cls(op)] - 1) begin
                m_k <= 0; m_cnt <= (m_cnt + 1) % (1 << CW);
            end else m_k <= m_k + 1;
        end
    end

    always @(negedge clk) begin
        int c, st;
        bit en, lv, ex;
        if (m_on) begin
            c  = cls(op);
            lv = !rst;
            en = lv && !hold && !m_trap;
            st = m_trap ? 5 : seq[c][m_k];
            ex = lv && st == 2;
            chk("state", state, lv ? st : 0);
            chk("inst_cnt", inst_cnt, lv ? m_cnt : 0);
            chk("ir_write", ir_write, en && st == 0);
            chk("pc_write", pc_write, en && (st == 0 || (c == K_J && st == 1) ||
                                             (c == K_BR && st == 2 && (zero ^ (op == 6'h05)))));
            chk("pc_src", pc_src, !lv ? 0 : (c == K_J && st == 1) ? 2 : (c == K_BR && st == 2) ? 1 : 0);
            chk("retire", retire, en && m_k == len[c] - 1
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                                  && c != K_NOP
`endif
            );
            chk("reg_write", reg_write, en && st == 4);
            chk("reg_dst", reg_dst, lv && st == 4 && op == 6'h00);
            chk("mem_to_reg", mem_to_reg, lv && st == 4 && op == 6'h23);
            chk("mem_write", mem_write, en && st == 3 && op == 6'h2B);
            chk("alu_src_b", alu_src_b, ex && op inside {6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B});
            chk("ext_sign", ext_sign, ex && op inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h05});
            chk("alu_ctl", alu_ctl, ex ? ealu(op, func) : 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            chk("illegal", illegal, lv && m_trap);
`endif
        end
    end

    task automatic step(input logic r, input logic h, input logic [5:0] o, input logic [5:0] f, input logic z);
        @(posedge clk);
        #1;
        rst = r; hold = h; op = o; func = f; zero = z;
        #1;
    endtask

    initial begin
        step(1, 0, 6'h00, 6'h20, 0);
        m_on = 1;
        step(1, 0, 6'h00, 6'h20, 0);
        chk("rst_state", state, 0);
        chk("rst_ir_write", ir_write, 0);
        step(0, 0, 6'h00, 6'h20, 0);
        chk("add_if_ir", ir_write, 1);
        step(0, 0, 6'h00, 6'h20, 0);
        chk("add_id", state, 1);
        step(0, 0, 6'h00, 6'h20, 0);
        chk("add_ex_alu", alu_ctl, 0);
        step(0, 0, 6'h00, 6'h20, 0);
        chk("add_wb_rw", {reg_write, reg_dst, retire}, 3'b111);
        step(0, 0, 6'h23, 6'h00, 0);
        chk("add_cnt", inst_cnt, 1);
        repeat (3) step(0, 0, 6'h23, 6'h00, 0);
        chk("lw_mem", {state, reg_write, retire}, {3'd3, 2'b00});
        step(0, 0, 6'h23, 6'h00, 0);
        chk("lw_wb", {mem_to_reg, reg_write, retire}, 3'b111);
        repeat (3) step(0, 0, 6'h2B, 6'h00, 0);
        step(0, 0, 6'h2B, 6'h00, 0);
        chk("sw_mem", {mem_write, retire, reg_write}, 3'b110);
        step(0, 0, 6'h04, 6'h00, 1);
        chk("lwsw_cnt", inst_cnt, 3);
        step(0, 0, 6'h04, 6'h00, 1);
        step(0, 0, 6'h04, 6'h00, 1);
        chk("beq_z1", {pc_write, pc_src, retire}, 4'b1011);
        repeat (2) step(0, 0, 6'h04, 6'h00, 0);
        step(0, 0, 6'h04, 6'h00, 0);
        chk("beq_z0", {pc_write, pc_src}, 3'b001);
        repeat (2) step(0, 0, 6'h05, 6'h00, 0);
        step(0, 0, 6'h05, 6'h00, 0);
        chk("bne_z0", {pc_write, pc_src}, 3'b101);
        step(0, 0, 6'h02, 6'h00, 0);
        step(0, 0, 6'h02, 6'h00, 0);
        chk("j_id", {pc_write, pc_src, retire}, 4'b1101);
        step(0, 0, 6'h02, 6'h00, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 6'h02, 6'h00, 0);
            chk("hold_id", {state, pc_write, retire}, {3'd1, 2'b00});
        end
        step(0, 0, 6'h02, 6'h00, 0);
        chk("hold_rel", retire, 1);
        repeat (2) step(0, 0, 6'h08, 6'h00, 0);
        step(1, 0, 6'h08, 6'h00, 0);
        chk("rst_ex_rw", {reg_write, state}, 4'd0);
        step(0, 0, 6'h3F, 6'h00, 0);
        chk("rst_after", {state, inst_cnt}, 0);
        step(0, 0, 6'h3F, 6'h00, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("ill_id", retire, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 6'h3F, 6'h00, 0);
            chk("trap", {state, illegal}, {3'd5, 1'b1});
        end
        step(1, 0, 6'h02, 6'h00, 0);
`else
        chk("nop_id", retire, 1);
`endif
        for (int i = 0; i < 15; i++) begin
            step(0, 0, 6'h02, 6'h00, 0);
            step(0, 0, 6'h02, 6'h00, 0);
        end
        step(0, 0, 6'h02, 6'h00, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("cnt_15", inst_cnt, 15);
`else
        chk("cnt_wrap_nop", inst_cnt, 0);
`endif
        step(0, 0, 6'h02, 6'h00, 0);
        step(0, 0, 6'h02, 6'h00, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        chk("cnt_wrap", inst_cnt, 0);
`else
        chk("cnt_1", inst_cnt, 1);
`endif
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] o, f;
            o = op; f = func;
            if (m_k == 0 && !m_trap) begin
                o = ops[$urandom_range(0, 12)];
                f = fns[$urandom_range(0, 9)];
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, o, f, 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
